// File: rtl/outmux_ctrl.sv
// Output steering controller: routes one producer result to one of N consumer channels via a registered req/ack stage.
// Optional sticky invalid-select flag `err` is built when OUTMUX_CTRL_ERR_EN is defined.
module outmux_ctrl #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            t_c_req,
    output logic            t_c_ack,
    input  logic [SELW-1:0] sel,
    input  logic            t_d_req,
    output logic            t_d_ack,
    output logic [N-1:0]    i_k_req,
    input  logic [N-1:0]    i_k_ack,
    output logic            busy
`ifdef OUTMUX_CTRL_ERR_EN
    ,
    output logic            err
`endif
);

    localparam logic [SELW:0] L_N = (SELW+1)'(N);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SELW-1:0] r_sel_q;
    logic [SELW-1:0] w_sel_nxt;
    logic [N-1:0]    r_req;
    logic [N-1:0]    w_req_nxt;
    logic [N-1:0]    w_sel_dec;
    logic [N-1:0]    w_q_dec;
    logic            w_sel_ok;
    logic            w_ack_sel;
    logic            w_rdy;

    always_comb begin
        w_sel_dec = '0;
        w_q_dec   = '0;
        for (int j = 0; j < N; j++) begin
            w_sel_dec[j] = (sel == SELW'(j));
            w_q_dec[j]   = (r_sel_q == SELW'(j));
        end
    end

    assign w_sel_ok  = ({1'b0, sel} < L_N);
    // Only the ack of the channel currently being requested can drain the stage.
    assign w_ack_sel = (r_state == S_SEND) & (|(i_k_ack & w_q_dec));
    assign w_rdy     = reset_n & ((r_state == S_IDLE) | w_ack_sel);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_q;
        w_req_nxt   = r_req;
        t_c_ack     = 1'b0;
        t_d_ack     = 1'b0;
        if (w_ack_sel) begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = '0;
        end
        // A new accept overrides the drain so back-to-back transfers keep SEND.
        if (w_rdy && t_c_req) begin
            if (!w_sel_ok) begin
                t_c_ack = 1'b1;
            end else if (t_d_req) begin
                t_c_ack     = 1'b1;
                t_d_ack     = 1'b1;
                w_state_nxt = S_SEND;
                w_sel_nxt   = sel;
                w_req_nxt   = w_sel_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_sel_q <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel_q <= w_sel_nxt;
            r_req   <= w_req_nxt;
        end
    end

    assign i_k_req = r_req;
    assign busy    = (r_state == S_SEND);

`ifdef OUTMUX_CTRL_ERR_EN
    logic w_drop;
    logic r_err;

    assign w_drop = w_rdy & t_c_req & ~w_sel_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule
